// File: rtl/branch_predictor_btb_if.sv
// rtl/branch_predictor_btb_if.sv - IF-stage lookup and ID-stage training bus for the BTB
interface branch_predictor_btb_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc_f;
   logic            pred_taken_f;
   logic [XLEN-1:0] pred_target_f;
   logic            upd_valid_d;
   logic [XLEN-1:0] upd_pc_d;
   logic            upd_taken_d;
   logic [XLEN-1:0] upd_target_d;
   logic            pred_taken_d;
   logic [XLEN-1:0] pred_target_d;
   logic            stall_d;
   logic            mispredict_d;
   logic [XLEN-1:0] redirect_pc_d;

   modport master (
      output pc_f, upd_valid_d, upd_pc_d, upd_taken_d, upd_target_d,
             pred_taken_d, pred_target_d, stall_d,
      input  pred_taken_f, pred_target_f, mispredict_d, redirect_pc_d
   );

   modport slave (
      input  pc_f, upd_valid_d, upd_pc_d, upd_taken_d, upd_target_d,
             pred_taken_d, pred_target_d, stall_d,
      output pred_taken_f, pred_target_f, mispredict_d, redirect_pc_d
   );
endinterface

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with 2-bit direction counters and event counters
module branch_predictor_btb #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   branch_predictor_btb_if.slave bus,
   output logic [CNT_W-1:0]      hit_cnt,
   output logic [CNT_W-1:0]      mispred_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   logic             f_hit, u_hit, upd, mispredict;
   logic             wr_en_d;
   logic [1:0]       ctr_d;
   logic [XLEN-1:0]  target_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, mispred_cnt_q, mispred_cnt_d;

   assign f_idx = bus.pc_f[IDX_W+1:2];
   assign f_tag = bus.pc_f[XLEN-1:IDX_W+2];
   assign u_idx = bus.upd_pc_d[IDX_W+1:2];
   assign u_tag = bus.upd_pc_d[XLEN-1:IDX_W+2];

   // Lookup reads registered contents only, so a same-cycle update is not visible yet.
   assign f_hit = !rst && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   assign bus.pred_taken_f  = f_hit && ctr_q[f_idx][1];
   assign bus.pred_target_f = bus.pred_taken_f ? target_q[f_idx] : bus.pc_f + PC_STEP;

   assign upd        = bus.upd_valid_d && !bus.stall_d && !rst;
   assign mispredict = upd && ((bus.pred_taken_d != bus.upd_taken_d) ||
                               (bus.upd_taken_d && (bus.pred_target_d != bus.upd_target_d)));

   assign bus.mispredict_d  = mispredict;
   assign bus.redirect_pc_d = bus.upd_taken_d ? bus.upd_target_d : bus.upd_pc_d + PC_STEP;

   assign hit_cnt     = hit_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

   always_comb begin
      wr_en_d  = 1'b0;
      ctr_d    = ctr_q[u_idx];
      target_d = target_q[u_idx];
      if (upd) begin
         if (u_hit) begin
            wr_en_d = 1'b1;
            if (bus.upd_taken_d) begin
               ctr_d    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
               target_d = bus.upd_target_d;
            end else begin
               ctr_d    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
            end
         end else if (bus.upd_taken_d) begin
            // Miss-taken replaces whatever aliased entry lives at this index.
            wr_en_d  = 1'b1;
            ctr_d    = 2'b10;
            target_d = bus.upd_target_d;
         end
      end
      hit_cnt_d     = (f_hit && (hit_cnt_q != '1)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
      mispred_cnt_d = (mispredict && (mispred_cnt_q != '1)) ? mispred_cnt_q + CNT_W'(1)
                                                            : mispred_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b00;
         end
         hit_cnt_q     <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (wr_en_d) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= target_d;
            ctr_q[u_idx]    <= ctr_d;
         end
         hit_cnt_q     <= hit_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb
module tb_branch_predictor_btb;
   logic clk = 1'b0;
   logic rst;
   logic [15:0] hit_cnt, mispred_cnt;
   logic [1:0]  hit_cnt2, mispred_cnt2;

   branch_predictor_btb_if #(.XLEN(32)) bus ();
   branch_predictor_btb_if #(.XLEN(32)) bus2 ();

   branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt));

   branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave), .hit_cnt(hit_cnt2), .mispred_cnt(mispred_cnt2));

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pt;
      logic [31:0] ptgt;
      logic        mis;
      logic [31:0] rdr;
      logic [15:0] hc;
      logic [15:0] mc;
   } exp_t;

   exp_t exp_q[$];
   exp_t obs_q[$];
   int total = 0;
   int bad   = 0;

   bit          m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   logic [1:0]  m_ctr   [16];
   int          m_hc = 0;
   int          m_mc = 0;

   task automatic drive(input logic r, input logic [31:0] pc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic pt, input logic [31:0] ptgt, input logic st);
      exp_t e;
      exp_t o;
      int   fi, ui;
      bit   hit, upd, uhit;
      @(negedge clk);
      rst = r;
      bus.pc_f = pc; bus.upd_valid_d = uv; bus.upd_pc_d = upc; bus.upd_taken_d = ut;
      bus.upd_target_d = utgt; bus.pred_taken_d = pt; bus.pred_target_d = ptgt; bus.stall_d = st;
      fi     = int'(pc[5:2]);
      hit    = !r && m_valid[fi] && (m_tag[fi] == pc[31:6]);
      e.pt   = hit && m_ctr[fi][1];
      e.ptgt = e.pt ? m_tgt[fi] : pc + 32'd4;
      upd    = uv && !st && !r;
      e.mis  = upd && ((pt != ut) || (ut && (ptgt != utgt)));
      e.rdr  = ut ? utgt : upc + 32'd4;
      e.hc   = 16'(m_hc);
      e.mc   = 16'(m_mc);
      exp_q.push_back(e);
      #1;
      o = {bus.pred_taken_f, bus.pred_target_f, bus.mispredict_d, bus.redirect_pc_d,
           hit_cnt, mispred_cnt};
      obs_q.push_back(o);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         m_hc = 0;
         m_mc = 0;
      end else begin
         if (hit && m_hc < 65535) m_hc++;
         if (e.mis && m_mc < 65535) m_mc++;
         if (upd) begin
            ui   = int'(upc[5:2]);
            uhit = m_valid[ui] && (m_tag[ui] == upc[31:6]);
            if (uhit && ut) begin
               if (m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'd1;
               m_tgt[ui] = utgt;
            end else if (uhit) begin
               if (m_ctr[ui] != 2'b00) m_ctr[ui] = m_ctr[ui] - 2'd1;
            end else if (ut) begin
               m_valid[ui] = 1'b1;
               m_tag[ui]   = upc[31:6];
               m_tgt[ui]   = utgt;
               m_ctr[ui]   = 2'b10;
            end
         end
      end
   endtask

   task automatic test_reset();
      exp_t e, o;
      int n = 0;
      drive(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0);
      drive(0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL reset step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_alloc();
      exp_t e, o;
      int n = 0;
      drive(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0);
      drive(0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL alloc step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_decay();
      exp_t e, o;
      int n = 0;
      logic pts [3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++)
         drive(0, 32'h100, 1, 32'h100, 0, 32'h0, pts[i], 32'h200, 0);
      drive(0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL decay step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_same_cycle();
      exp_t e, o;
      int n = 0;
      drive(1, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0);
      drive(0, 32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL same_cycle step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_alias();
      exp_t e, o;
      int n = 0;
      drive(0, 32'h140, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0);
      drive(0, 32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h100, 1, 32'h140, 1, 32'h300, 1, 32'h300, 0);
      drive(0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL alias step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_stall();
      exp_t e, o;
      int n = 0;
      drive(0, 32'h140, 1, 32'h140, 0, 32'h0, 1, 32'h300, 1);
      drive(0, 32'h180, 1, 32'h180, 1, 32'h500, 0, 32'h184, 1);
      drive(0, 32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h180, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL stall step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e, o;
      int n = 0;
      drive(1, 32'h140, 1, 32'h1C0, 1, 32'h400, 0, 32'h1C4, 0);
      drive(0, 32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h1C0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL reset_mid step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e, o;
      int n = 0;
      logic [31:0] pcs  [5] = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h2100};
      logic [31:0] tgts [3] = '{32'h200, 32'h300, 32'h800};
      for (int i = 0; i < 60; i++)
         drive(0, pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
               1'($urandom_range(0, 1)), tgts[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
               tgts[$urandom_range(0, 2)], ($urandom_range(0, 4) == 0));
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL back_to_back step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_saturate();
      logic [3:0] q_exp[$];
      logic [3:0] q_obs[$];
      logic [3:0] e, o;
      int hc, n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus2.pc_f = 32'h100; bus2.upd_valid_d = (k <= 6); bus2.upd_pc_d = 32'h100;
         bus2.upd_taken_d = 1'b1; bus2.upd_target_d = 32'h200; bus2.pred_taken_d = 1'b0;
         bus2.pred_target_d = 32'h104; bus2.stall_d = 1'b0;
         hc = (k == 0) ? 0 : ((k - 1 > 3) ? 3 : k - 1);
         q_exp.push_back({2'(hc), 2'((k > 3) ? 3 : k)});
         #1;
         q_obs.push_back({hit_cnt2, mispred_cnt2});
         @(posedge clk);
      end
      while (q_exp.size() != 0) begin
         e = q_exp.pop_front(); o = q_obs.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL saturate step%0d: got %h want %h", n, o, e); end
         n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.pc_f = '0; bus.upd_valid_d = 1'b0; bus.upd_pc_d = '0; bus.upd_taken_d = 1'b0;
      bus.upd_target_d = '0; bus.pred_taken_d = 1'b0; bus.pred_target_d = '0; bus.stall_d = 1'b0;
      bus2.pc_f = '0; bus2.upd_valid_d = 1'b0; bus2.upd_pc_d = '0; bus2.upd_taken_d = 1'b0;
      bus2.upd_target_d = '0; bus2.pred_taken_d = 1'b0; bus2.pred_target_d = '0; bus2.stall_d = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b00;
      end
      repeat (2) @(posedge clk);
      test_reset();
      test_alloc();
      test_decay();
      test_same_cycle();
      test_alias();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
